// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
//
// Pipeline register between the decode (ID) and execute (EX) stages of a
// five-stage MIPS-style core.  Besides carrying the decoded instruction
// forward it detects the classic load-use hazard (a load in EX whose
// destination is read by the instruction in ID).  When that hazard is seen
// it inserts one bubble into EX and raises a combinational stall towards the
// PC and IF/ID registers.  It also keeps a saturating count of inserted
// bubbles.
//
// Ports
//   clk                     single clock, all state updates on rising edge
//   reset                   synchronous, active-low
//   hold                    global freeze, every register keeps its value
//   flush                   squash the ID instruction (EX receives a bubble)
//   id_valid                ID slot holds a real instruction
//   id_ctrl[15:0]           packed decode:
//                             {RegDst[15:14], MemToReg[13:12], ALUFun[11:6],
//                              RegWr[5], ALUSrc1[4], ALUSrc2[3], Sign[2],
//                              MemWr[1], MemRd[0]}
//   id_PC4/id_A/id_B/id_imm 32-bit PC+4, rs data, rt data, extended immediate
//   id_rs/id_rt/id_rd/id_shamt  5-bit register numbers and shift amount
//   ex_*                    registered copies of the id_* inputs
//   stall                   combinational load-use stall to PC and IF/ID
//   stall_cnt[15:0]         registered, saturating count of bubbles inserted
// ---------------------------------------------------------------------------
module id_ex_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [15:0] id_ctrl,
    input  logic [31:0] id_PC4,
    input  logic [31:0] id_A,
    input  logic [31:0] id_B,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_shamt,
    output logic        ex_valid,
    output logic [15:0] ex_ctrl,
    output logic [31:0] ex_PC4,
    output logic [31:0] ex_A,
    output logic [31:0] ex_B,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_shamt,
    output logic        stall,
    output logic [15:0] stall_cnt
);

    logic        hazard;
    logic        ex_is_load;
    logic        rt_nonzero;
    logic        src_match;
    logic [15:0] cnt_q;
    logic [15:0] cnt_inc;

    // Load-use detection.  The load in EX writes ex_rt; if the ID instruction
    // reads that register it must wait one cycle.  Register 0 is hardwired to
    // zero, so a load "into" $0 never creates a dependency.
    always_comb begin
        ex_is_load = ex_valid & ex_ctrl[0];
        rt_nonzero = (ex_rt != 5'd0);
        src_match  = (ex_rt == id_rs) | (ex_rt == id_rt);
        hazard     = ex_is_load & rt_nonzero & id_valid & src_match;
    end

    // A flush or a freeze makes the stall pointless: the ID instruction is
    // either being discarded or nothing is moving anyway.  This stays purely
    // combinational, even while reset is asserted.
    assign stall = hazard & ~flush & ~hold;

    // Saturating increment so a long run never wraps back to a small number.
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    assign stall_cnt = cnt_q;

    // Stage register.  Priority per edge: reset, hold, flush, hazard bubble,
    // normal load.  A bubble clears ex_ctrl, so the hazard disappears on the
    // following cycle and each load-use costs exactly one stall cycle.  On a
    // normal load of an invalid slot the control word is zeroed so that
    // RegWr/MemWr/MemRd cannot fire for a non-instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= 16'd0;
            ex_PC4   <= 32'd0;
            ex_A     <= 32'd0;
            ex_B     <= 32'd0;
            ex_imm   <= 32'd0;
            ex_rs    <= 5'd0;
            ex_rt    <= 5'd0;
            ex_rd    <= 5'd0;
            ex_shamt <= 5'd0;
            cnt_q    <= 16'd0;
        end else if (hold) begin
            ex_valid <= ex_valid;
            ex_ctrl  <= ex_ctrl;
            ex_PC4   <= ex_PC4;
            ex_A     <= ex_A;
            ex_B     <= ex_B;
            ex_imm   <= ex_imm;
            ex_rs    <= ex_rs;
            ex_rt    <= ex_rt;
            ex_rd    <= ex_rd;
            ex_shamt <= ex_shamt;
            cnt_q    <= cnt_q;
        end else if (flush || hazard) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= 16'd0;
            ex_PC4   <= 32'd0;
            ex_A     <= 32'd0;
            ex_B     <= 32'd0;
            ex_imm   <= 32'd0;
            ex_rs    <= 5'd0;
            ex_rt    <= 5'd0;
            ex_rd    <= 5'd0;
            ex_shamt <= 5'd0;
            // Only a genuine load-use bubble is counted; a flush wins over a
            // simultaneous hazard and leaves the count alone.
            cnt_q    <= flush ? cnt_q : cnt_inc;
        end else begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_valid ? id_ctrl : 16'd0;
            ex_PC4   <= id_PC4;
            ex_A     <= id_A;
            ex_B     <= id_B;
            ex_imm   <= id_imm;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
            ex_shamt <= id_shamt;
            cnt_q    <= cnt_q;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_reg
//
// Directed testbench for id_ex_reg.  Each task drives one scenario and checks
// the registered outputs one time unit after the rising edge, and the
// combinational stall one time unit after the inputs change.
// ---------------------------------------------------------------------------
module tb_id_ex_reg;

    logic        clk;
    logic        reset;
    logic        hold;
    logic        flush;
    logic        id_valid;
    logic [15:0] id_ctrl;
    logic [31:0] id_PC4;
    logic [31:0] id_A;
    logic [31:0] id_B;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic        ex_valid;
    logic [15:0] ex_ctrl;
    logic [31:0] ex_PC4;
    logic [31:0] ex_A;
    logic [31:0] ex_B;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_shamt;
    logic        stall;
    logic [15:0] stall_cnt;

    int checks;
    int fails;

    localparam logic [15:0] LW_CTRL  = 16'h1029;
    localparam logic [15:0] ALU_CTRL = 16'h4020;

    id_ex_reg dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_ctrl(id_ctrl), .id_PC4(id_PC4),
        .id_A(id_A), .id_B(id_B), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_PC4(ex_PC4),
        .ex_A(ex_A), .ex_B(ex_B), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the ID slot.  Secondary fields are derived from A/rs/rt so every
    // field carries a distinct, hand-computable value.
    task automatic drive_id(input logic v, input logic [15:0] c,
                            input logic [4:0] rs, input logic [4:0] rt,
                            input logic [31:0] a);
        id_valid = v;
        id_ctrl  = c;
        id_A     = a;
        id_PC4   = a + 32'd4;
        id_B     = ~a;
        id_imm   = a ^ 32'h0F0F0F0F;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rs ^ rt;
        id_shamt = rs + rt;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        hold  = 1'b1;
        flush = 1'b1;
        drive_id(1'b1, ALU_CTRL, 5'd4, 5'd5, 32'hDEADBEEF);
        step();
        checks++; if (ex_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %0b want 0", ex_valid); end
        checks++; if (ex_ctrl !== 16'h0) begin fails++; $display("[TB] FAIL reset_ctrl: got %h want 0000", ex_ctrl); end
        checks++; if (ex_A !== 32'h0) begin fails++; $display("[TB] FAIL reset_A: got %h want 0", ex_A); end
        checks++; if (stall_cnt !== 16'h0) begin fails++; $display("[TB] FAIL reset_cnt: got %h want 0000", stall_cnt); end
        checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall: got %0b want 0", stall); end
        reset = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_normal();
        drive_id(1'b1, ALU_CTRL, 5'd1, 5'd2, 32'h12345678);
        checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL normal_stall: got %0b want 0", stall); end
        step();
        checks++; if (ex_ctrl !== 16'h4020) begin fails++; $display("[TB] FAIL normal_ctrl: got %h want 4020", ex_ctrl); end
        checks++; if (ex_A !== 32'h12345678) begin fails++; $display("[TB] FAIL normal_A: got %h want 12345678", ex_A); end
        checks++; if (ex_valid !== 1'b1) begin fails++; $display("[TB] FAIL normal_valid: got %0b want 1", ex_valid); end
        checks++; if (ex_PC4 !== 32'h1234567C) begin fails++; $display("[TB] FAIL normal_PC4: got %h want 1234567c", ex_PC4); end
        checks++; if (ex_B !== 32'hEDCBA987) begin fails++; $display("[TB] FAIL normal_B: got %h want edcba987", ex_B); end
        checks++; if (ex_imm !== 32'h1D3B5977) begin fails++; $display("[TB] FAIL normal_imm: got %h want 1d3b5977", ex_imm); end
        checks++; if ({ex_rs, ex_rt, ex_rd, ex_shamt} !== {5'd1, 5'd2, 5'd3, 5'd3}) begin
            fails++; $display("[TB] FAIL normal_regs: got %0d %0d %0d %0d want 1 2 3 3", ex_rs, ex_rt, ex_rd, ex_shamt);
        end
        checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL normal_stall_after: got %0b want 0", stall); end
    endtask

    task automatic test_invalid_slot();
        drive_id(1'b0, 16'hFFFF, 5'd6, 5'd7, 32'h0BADF00D);
        step();
        checks++; if (ex_ctrl !== 16'h0) begin fails++; $display("[TB] FAIL invalid_ctrl: got %h want 0000", ex_ctrl); end
        checks++; if (ex_valid !== 1'b0) begin fails++; $display("[TB] FAIL invalid_valid: got %0b want 0", ex_valid); end
        checks++; if (ex_A !== 32'h0BADF00D) begin fails++; $display("[TB] FAIL invalid_A: got %h want 0badf00d", ex_A); end
    endtask

    task automatic test_load_use();
        // Dependency through rs.
        drive_id(1'b1, LW_CTRL, 5'd9, 5'd8, 32'h00001000);
        step();
        drive_id(1'b1, ALU_CTRL, 5'd8, 5'd10, 32'h55AA55AA);
        checks++; if (stall !== 1'b1) begin fails++; $display("[TB] FAIL lu_rs_stall: got %0b want 1", stall); end
        step();
        checks++; if (ex_ctrl !== 16'h0) begin fails++; $display("[TB] FAIL lu_bubble_ctrl: got %h want 0000", ex_ctrl); end
        checks++; if (ex_valid !== 1'b0) begin fails++; $display("[TB] FAIL lu_bubble_valid: got %0b want 0", ex_valid); end
        checks++; if (stall_cnt !== 16'd1) begin fails++; $display("[TB] FAIL lu_cnt1: got %0d want 1", stall_cnt); end
        checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL lu_stall_cleared: got %0b want 0", stall); end
        step();
        checks++; if (ex_ctrl !== ALU_CTRL) begin fails++; $display("[TB] FAIL lu_resume_ctrl: got %h want 4020", ex_ctrl); end
        checks++; if (ex_A !== 32'h55AA55AA) begin fails++; $display("[TB] FAIL lu_resume_A: got %h want 55aa55aa", ex_A); end
        checks++; if (stall_cnt !== 16'd1) begin fails++; $display("[TB] FAIL lu_cnt_hold: got %0d want 1", stall_cnt); end
        // Dependency through rt.
        drive_id(1'b1, LW_CTRL, 5'd9, 5'd8, 32'h00001004);
        step();
        drive_id(1'b1, ALU_CTRL, 5'd3, 5'd8, 32'h66666666);
        checks++; if (stall !== 1'b1) begin fails++; $display("[TB] FAIL lu_rt_stall: got %0b want 1", stall); end
        step();
        checks++; if (stall_cnt !== 16'd2) begin fails++; $display("[TB] FAIL lu_cnt2: got %0d want 2", stall_cnt); end
        step();
        checks++; if (ex_rt !== 5'd8 || ex_valid !== 1'b1) begin
            fails++; $display("[TB] FAIL lu_rt_resume: got rt=%0d valid=%0b want rt=8 valid=1", ex_rt, ex_valid);
        end
    endtask

    task automatic test_zero_reg();
        drive_id(1'b1, LW_CTRL, 5'd9, 5'd0, 32'h00002000);
        step();
        drive_id(1'b1, ALU_CTRL, 5'd0, 5'd0, 32'h77777777);
        checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL zero_stall: got %0b want 0", stall); end
        step();
        checks++; if (ex_ctrl !== ALU_CTRL || ex_valid !== 1'b1) begin
            fails++; $display("[TB] FAIL zero_load: got ctrl=%h valid=%0b want ctrl=4020 valid=1", ex_ctrl, ex_valid);
        end
        checks++; if (stall_cnt !== 16'd2) begin fails++; $display("[TB] FAIL zero_cnt: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_flush_hazard();
        drive_id(1'b1, LW_CTRL, 5'd9, 5'd8, 32'h00003000);
        step();
        flush = 1'b1;
        drive_id(1'b1, ALU_CTRL, 5'd8, 5'd1, 32'h88888888);
        checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL flush_stall: got %0b want 0", stall); end
        step();
        flush = 1'b0;
        checks++; if ({ex_valid, ex_ctrl, ex_A, ex_PC4, ex_rs, ex_rt} !== '0) begin
            fails++; $display("[TB] FAIL flush_bubble: got valid=%0b ctrl=%h A=%h rs=%0d rt=%0d want all 0", ex_valid, ex_ctrl, ex_A, ex_rs, ex_rt);
        end
        checks++; if (stall_cnt !== 16'd2) begin fails++; $display("[TB] FAIL flush_cnt: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_hold();
        drive_id(1'b1, LW_CTRL, 5'd9, 5'd8, 32'hAAAA0000);
        step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, ALU_CTRL, (i == 0) ? 5'd8 : 5'(20 + i), 5'd1, 32'(i));
            checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL hold_stall%0d: got %0b want 0", i, stall); end
            step();
            checks++; if (ex_ctrl !== LW_CTRL || ex_A !== 32'hAAAA0000 || ex_rt !== 5'd8 || stall_cnt !== 16'd2) begin
                fails++; $display("[TB] FAIL hold_keep%0d: got ctrl=%h A=%h rt=%0d cnt=%0d want 1029 aaaa0000 8 2", i, ex_ctrl, ex_A, ex_rt, stall_cnt);
            end
        end
        hold = 1'b0;
        drive_id(1'b1, ALU_CTRL, 5'd11, 5'd12, 32'hBBBB0000);
        step();
        checks++; if (ex_rs !== 5'd11 || ex_A !== 32'hBBBB0000) begin
            fails++; $display("[TB] FAIL hold_resume: got rs=%0d A=%h want 11 bbbb0000", ex_rs, ex_A);
        end
    endtask

    task automatic test_reset_midstall();
        drive_id(1'b1, LW_CTRL, 5'd9, 5'd8, 32'h00004000);
        step();
        drive_id(1'b1, ALU_CTRL, 5'd8, 5'd2, 32'hCCCC0000);
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("[TB] FAIL midreset_stall: got %0b want 1", stall); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 16'h0 || stall_cnt !== 16'd0 || stall !== 1'b0) begin
            fails++; $display("[TB] FAIL midreset_clear: got valid=%0b ctrl=%h cnt=%0d stall=%0b want 0", ex_valid, ex_ctrl, stall_cnt, stall);
        end
        reset = 1'b1;
        step();
        checks++; if (ex_ctrl !== ALU_CTRL || ex_A !== 32'hCCCC0000 || ex_valid !== 1'b1 || stall_cnt !== 16'd0) begin
            fails++; $display("[TB] FAIL midreset_load: got ctrl=%h A=%h valid=%0b cnt=%0d want 4020 cccc0000 1 0", ex_ctrl, ex_A, ex_valid, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        // Counting to 16'hFFFF through real hazards would take ~131k cycles,
        // so the counter is preset near the top and then pushed over it.
        drive_id(1'b1, LW_CTRL, 5'd9, 5'd8, 32'h00005000);
        step();
        force dut.cnt_q = 16'hFFFE;
        drive_id(1'b1, ALU_CTRL, 5'd8, 5'd1, 32'h0);
        step();
        release dut.cnt_q;
        for (int i = 0; i < 2; i++) begin
            drive_id(1'b1, LW_CTRL, 5'd9, 5'd8, 32'h00006000);
            step();
            drive_id(1'b1, ALU_CTRL, 5'd8, 5'd1, 32'h0);
            checks++; if (stall !== 1'b1) begin fails++; $display("[TB] FAIL sat_stall%0d: got %0b want 1", i, stall); end
            step();
        end
        checks++; if (stall_cnt !== 16'hFFFF) begin fails++; $display("[TB] FAIL sat_cnt: got %h want ffff", stall_cnt); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++; if (stall_cnt !== 16'h0 || ex_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL sat_reset: got cnt=%h valid=%0b want 0000 0", stall_cnt, ex_valid);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b0;
        hold   = 1'b0;
        flush  = 1'b0;
        drive_id(1'b0, 16'h0, 5'd0, 5'd0, 32'h0);
        test_reset();
        test_normal();
        test_invalid_slot();
        test_load_use();
        test_zero_reg();
        test_flush_hazard();
        test_hold();
        test_reset_midstall();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
